sipo_deserializer: RTL and testbench

Serial-in/parallel-out front end that assembles a qualified serial bit stream into WIDTH-bit words. It presents each word on a registered parallel bus with a valid/ready handshake. It sits directly upstream of the team's parallel-in/parallel-out holding register, whose pi input it drives. A one-word output buffer decouples assembly from the consumer, and an overrun flag reports words lost under backpressure.

---
 rtl/sipo_deserializer_if.sv | 27 ++
 rtl/sipo_deserializer.sv | 80 ++++++++
 tb/tb_sipo_deserializer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/sipo_deserializer_if.sv
// Serial stream, handshake and status bundle for sipo_deserializer.
// master = stream source / word consumer, slave = the deserializer.
interface sipo_deserializer_if #(
  parameter int WIDTH = 4
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             si;
  logic             si_en;
  logic             resync;
  logic [WIDTH-1:0] po;
  logic             po_valid;
  logic             po_ready;
  logic             overrun;
  logic             ovr_clr;
  logic [CNT_W-1:0] bit_cnt;

  modport master (
    output si, si_en, resync, po_ready, ovr_clr,
    input  po, po_valid, overrun, bit_cnt
  );

  modport slave (
    input  si, si_en, resync, po_ready, ovr_clr,
    output po, po_valid, overrun, bit_cnt
  );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer with a one-word output buffer,
// valid/ready handshake and sticky overrun flag.
module sipo_deserializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 clear,
  sipo_deserializer_if.slave   bus
);
  localparam int              CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] po_q, po_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vld_q, vld_d;
  logic             ovr_q, ovr_d;
  logic             sample, complete, buf_free;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sr,
                                                input logic             b);
    if (MSB_FIRST) shift_in = {sr[WIDTH-2:0], b};
    else           shift_in = {b, sr[WIDTH-1:1]};
  endfunction

  always_comb begin
    sample   = bus.si_en && !bus.resync;
    complete = sample && (cnt_q == LAST);
    buf_free = !vld_q || bus.po_ready;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    po_d     = po_q;
    vld_d    = vld_q;
    ovr_d    = ovr_q;

    if (bus.resync) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (sample) begin
      sr_d  = shift_in(sr_q, bus.si);
      cnt_d = complete ? '0 : cnt_q + 1'b1;
    end

    if (bus.ovr_clr) ovr_d = 1'b0;

    // The completed word is the post-shift value, so it already holds the last bit.
    if (complete) begin
      if (buf_free) begin
        po_d  = sr_d;
        vld_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (vld_q && bus.po_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      sr_q  <= '0;
      cnt_q <= '0;
      po_q  <= '0;
      vld_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      po_q  <= po_d;
      vld_q <= vld_d;
      ovr_q <= ovr_d;
    end
  end

  assign bus.po       = po_q;
  assign bus.po_valid = vld_q;
  assign bus.overrun  = ovr_q;
  assign bus.bit_cnt  = cnt_q;
endmodule

// File: tb/tb_sipo_deserializer.sv
// Randomized and directed bench for sipo_deserializer; an MSB-first and an
// LSB-first instance share one stimulus and are compared against a word-level model.
module tb_sipo_deserializer;
  localparam int W = 4;

  logic clk   = 1'b0;
  logic clear = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  sipo_deserializer_if #(.WIDTH(W)) if_msb ();
  sipo_deserializer_if #(.WIDTH(W)) if_lsb ();

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .clear(clear), .bus(if_msb)
  );
  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .clear(clear), .bus(if_lsb)
  );

  always #5 clk = ~clk;

  // Reference: received bits kept as a list; a word is built once W have arrived.
  bit           bits_m [2][W];
  int           cnt_m  [2];
  logic [W-1:0] po_m   [2];
  bit           vld_m  [2];
  bit           ovr_m  [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      cnt_m[k] = 0;
      po_m[k]  = '0;
      vld_m[k] = 1'b0;
      ovr_m[k] = 1'b0;
    end
  endtask

  task automatic model_step(input bit si, input bit en, input bit rs,
                            input bit rdy, input bit oc);
    for (int k = 0; k < 2; k++) begin
      bit           done = 1'b0;
      bit           drop = 1'b0;
      logic [W-1:0] w    = '0;
      if (rs) cnt_m[k] = 0;
      else if (en) begin
        bits_m[k][cnt_m[k]] = si;
        cnt_m[k]++;
        if (cnt_m[k] == W) begin
          for (int i = 0; i < W; i++) begin
            if (k == 0) w[W-1-i] = bits_m[k][i];
            else        w[i]     = bits_m[k][i];
          end
          cnt_m[k] = 0;
          done     = 1'b1;
          if (!vld_m[k] || rdy) begin
            po_m[k]  = w;
            vld_m[k] = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end
      end
      if (!done && vld_m[k] && rdy) vld_m[k] = 1'b0;
      if (oc)   ovr_m[k] = 1'b0;
      if (drop) ovr_m[k] = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_msb_po"},  32'(if_msb.po),       32'(po_m[0]));
    chk({tag, "_msb_vld"}, 32'(if_msb.po_valid), 32'(vld_m[0]));
    chk({tag, "_msb_ovr"}, 32'(if_msb.overrun),  32'(ovr_m[0]));
    chk({tag, "_msb_cnt"}, 32'(if_msb.bit_cnt),  32'(cnt_m[0]));
    chk({tag, "_lsb_po"},  32'(if_lsb.po),       32'(po_m[1]));
    chk({tag, "_lsb_vld"}, 32'(if_lsb.po_valid), 32'(vld_m[1]));
    chk({tag, "_lsb_ovr"}, 32'(if_lsb.overrun),  32'(ovr_m[1]));
    chk({tag, "_lsb_cnt"}, 32'(if_lsb.bit_cnt),  32'(cnt_m[1]));
  endtask

  task automatic drive(input bit si, input bit en, input bit rs,
                       input bit rdy, input bit oc);
    if_msb.si = si; if_msb.si_en = en; if_msb.resync = rs;
    if_msb.po_ready = rdy; if_msb.ovr_clr = oc;
    if_lsb.si = si; if_lsb.si_en = en; if_lsb.resync = rs;
    if_lsb.po_ready = rdy; if_lsb.ovr_clr = oc;
  endtask

  task automatic cyc(input string tag, input bit si, input bit en, input bit rs,
                     input bit rdy, input bit oc);
    @(negedge clk);
    drive(si, en, rs, rdy, oc);
    model_step(si, en, rs, rdy, oc);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic send(input string tag, input logic [W-1:0] pat, input bit rdy);
    for (int i = W - 1; i >= 0; i--) cyc(tag, pat[i], 1'b1, 1'b0, rdy, 1'b0);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 clear = 1'b1;
    model_reset();
    #1 check_all(tag);
    #1 clear = 1'b0;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #3 check_all("reset");
    @(negedge clk);
    clear = 1'b0;

    // Basic MSB/LSB assembly, po_ready held high
    send("t1", 4'b1101, 1'b1);
    chk("t1_po_const", 32'(if_msb.po), 32'hd);
    chk("t1_vld_const", 32'(if_msb.po_valid), 32'h1);
    cyc("t1_idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t1_vld_drop", 32'(if_msb.po_valid), 32'h0);

    // Gapped input
    for (int i = 0; i < W; i++) begin
      bit b;
      logic [W-1:0] pat = 4'b1101;
      b = pat[W-1-i];
      cyc("t2", b, 1'b1, 1'b0, 1'b1, 1'b0);
      if (i != W - 1)
        for (int g = 0; g < 3; g++) cyc("t2_gap", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    chk("t2_lsb_po_const", 32'(if_lsb.po), 32'hb);
    cyc("t2_idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Backpressure and overrun
    send("t3a", 4'b1001, 1'b0);
    send("t3b", 4'b0110, 1'b0);
    chk("t3_po_held", 32'(if_msb.po), 32'h9);
    chk("t3_ovr_set", 32'(if_msb.overrun), 32'h1);
    cyc("t3_accept", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("t3_ovrclr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_ovr_clr", 32'(if_msb.overrun), 32'h0);

    // Accept and load on the same edge
    send("t4a", 4'b1001, 1'b0);
    cyc("t4b", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("t4b", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("t4b", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("t4b", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t4_po_const", 32'(if_msb.po), 32'h6);
    chk("t4_ovr_const", 32'(if_msb.overrun), 32'h0);
    cyc("t4_idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // resync mid-word
    cyc("t5", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc("t5", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc("t5_rs", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    send("t5", 4'b0011, 1'b1);
    chk("t5_po_const", 32'(if_msb.po), 32'h3);
    cyc("t5_idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // resync on the completing edge, plus ovr_clr racing an overrun set
    send("t5c", 4'b0101, 1'b0);
    cyc("t5c", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("t5c", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("t5c", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("t5c_rs", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t5c_no_ovr", 32'(if_msb.overrun), 32'h0);
    send("t5d", 4'b1110, 1'b0);
    cyc("t5e", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("t5e", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("t5e", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("t5e_setwins", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("t5e_ovr_const", 32'(if_msb.overrun), 32'h1);

    // Async reset mid-word while holding a word and overrun
    async_reset("t6_pre");
    send("t6a", 4'b1101, 1'b0);
    send("t6b", 4'b0000, 1'b0);
    cyc("t6c", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("t6c", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_pre_ovr", 32'(if_msb.overrun), 32'h1);
    async_reset("t6_rst");
    chk("t6_po_zero", 32'(if_msb.po), 32'h0);
    send("t6d", 4'b1010, 1'b1);
    chk("t6_po_const", 32'(if_msb.po), 32'ha);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) async_reset("rnd_rst");
      else cyc("rnd", 1'($urandom), ($urandom_range(0, 9) < 7),
               ($urandom_range(0, 39) == 0), 1'($urandom),
               ($urandom_range(0, 19) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
